fetch_unit: RTL and testbench

Instruction fetch and program-counter stage that sits directly upstream of the control unit. It holds the PC, fetches one instruction per execution window from instruction memory over a req/ack handshake, and presents the opcode to the control unit for the fixed 8-cycle window. At the window's last cycle it commits the next PC from the control unit's PC-mux select and the `equ`/`les` flags.

---
 rtl/fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and instruction fetch stage feeding the control unit.
// Fetches one instruction per window over a req/ack handshake, holds it for an
// 8-cycle EXEC window, and commits the next PC on the window's last phase.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch watchdog, sticky fetch_err).
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [2:0]        phase,
    output logic              stall,
    input  logic [2:0]        pc_sel,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              equ,
    input  logic              les,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err
);

    localparam logic [2:0] LAST_PHASE = 3'd7;
    localparam logic [5:0] OP_BEQ     = 6'd30;
    localparam logic [5:0] OP_BLT     = 6'd31;

    // Elaboration-time parameter sanity checks
    if (ADDR_W < 8 || ADDR_W > 26) begin : g_bad_addr_w
        $error("fetch_unit: ADDR_W must be in 8..26");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [2:0]        phase_q, phase_d;

    logic              commit_c;
    logic              halt_c;
    logic              taken_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] br_off_c;
    logic [ADDR_W-1:0] pc_next_c;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             fetch_err_q, fetch_err_d;
    logic             timeout_c;

    // Watchdog expires on the TIMEOUT-th FETCH cycle without an ack
    assign timeout_c = (state_q == S_FETCH) && !imem_ack
                       && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Watchdog counter, timed-out-window flag and sticky error flag
    always_comb begin
        cnt_d       = '0;
        to_d        = to_q;
        fetch_err_d = fetch_err_q;
        if (state_q == S_FETCH) begin
            cnt_d = cnt_q + CNT_W'(1);
            to_d  = 1'b0;
            if (timeout_c) begin
                to_d        = 1'b1;
                fetch_err_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            to_q        <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            fetch_err_q <= fetch_err_d;
        end
    end
`endif

    // Next-PC selection evaluated at commit
    always_comb begin
        commit_c = (state_q == S_EXEC) && (phase_q == LAST_PHASE);
        pc_inc_c = pc_q + ADDR_W'(1);
        br_off_c = ADDR_W'(32'($signed(instr_q[15:0])));
        taken_c  = ((instr_q[31:26] == OP_BEQ) && equ)
                || ((instr_q[31:26] == OP_BLT) && les);
        halt_c   = (pc_sel == 3'd4);
`ifdef FETCH_TIMEOUT_EN
        halt_c   = halt_c || to_q;
`endif
        pc_next_c = pc_inc_c;
        case (pc_sel)
            3'd0:    pc_next_c = instr_q[ADDR_W-1:0];
            3'd1:    pc_next_c = taken_c ? (pc_inc_c + br_off_c) : pc_inc_c;
            3'd2:    pc_next_c = reg_target;
            default: pc_next_c = pc_inc_c;
        endcase
        if (halt_c) begin
            pc_next_c = pc_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                if (timeout_c) begin
                    state_d = S_EXEC;
                end
`endif
            end
            S_EXEC:  begin
                if (commit_c) begin
                    state_d = halt_c ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: instruction latch, phase counter, PC commit
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        phase_d = phase_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    phase_d = '0;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_c) begin
                    instr_d = '0;
                    phase_d = '0;
                end
`endif
            end
            S_EXEC: begin
                phase_d = phase_q + 3'd1;
                if (commit_c) begin
                    pc_d = pc_next_c;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            phase_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            phase_q <= phase_d;
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        imem_addr   = pc_q;
        pc          = pc_q;
        instr       = instr_q;
        opcode      = instr_q[31:26];
        phase       = phase_q;
        instr_valid = (state_q == S_EXEC) && (phase_q == 3'd0);
        stall       = (state_q != S_EXEC);
        halted      = (state_q == S_HALT);
`ifdef FETCH_TIMEOUT_EN
        fetch_err   = fetch_err_q;
`else
        fetch_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (ADDR_W=16, RESET_PC=0, TIMEOUT=16).
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [2:0]  phase;
    logic        stall;
    logic [2:0]  pc_sel;
    logic [15:0] reg_target;
    logic        equ;
    logic        les;
    logic [15:0] pc;
    logic        halted;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .phase       (phase),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .reg_target  (reg_target),
        .equ         (equ),
        .les         (les),
        .pc          (pc),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full window starting in FETCH: ack at once, 8 EXEC cycles, commit.
    // EXEC-time acks carry a different word to show they are ignored.
    task automatic do_window(input string tag, input logic [31:0] word,
                             input logic [2:0] sel, input logic e, input logic l,
                             input logic [15:0] tgt, input logic [15:0] exp_pc,
                             input logic exp_req);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        chk({tag, ".valid0"}, 32'(instr_valid), 32'd1);
        chk({tag, ".instr0"}, instr, word);
        chk({tag, ".stall0"}, 32'(stall), 32'd0);
        imem_rdata = ~word;
        pc_sel     = sel;
        equ        = e;
        les        = l;
        reg_target = tgt;
        repeat (7) tick();
        chk({tag, ".phase7"}, 32'(phase), 32'd7);
        chk({tag, ".instr7"}, instr, word);
        chk({tag, ".valid7"}, 32'(instr_valid), 32'd0);
        tick();
        imem_ack   = 1'b0;
        pc_sel     = 3'd4;
        equ        = ~e;
        les        = ~l;
        reg_target = 16'hBEEF;
        chk({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, ".addr"}, 32'(imem_addr), 32'(exp_pc));
        chk({tag, ".req"}, 32'(imem_req), 32'(exp_req));
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc_sel     = 3'd3;
        reg_target = '0;
        equ        = 1'b0;
        les        = 1'b0;

        // Reset values
        #12;
        chk("rst.pc", 32'(pc), 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", 32'(imem_addr), 32'h0);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.phase", 32'(phase), 32'd0);
        chk("rst.stall", 32'(stall), 32'd1);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.ferr", 32'(fetch_err), 32'd0);

        // IDLE for one cycle, then FETCH at RESET_PC
        tick();
        rst_n = 1'b1;
        chk("idle.req", 32'(imem_req), 32'd0);
        tick();
        chk("fetch0.req", 32'(imem_req), 32'd1);
        chk("fetch0.stall", 32'(stall), 32'd1);

        // Sequential flow
        do_window("seq1", 32'h0C00_0000, 3'd3, 1'b0, 1'b0, 16'h0, 16'h0001, 1'b1);
        do_window("seq2", 32'h0C00_0001, 3'd3, 1'b0, 1'b0, 16'h0, 16'h0002, 1'b1);
        // Jumps
        do_window("jabs", 32'h7000_0040, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0040, 1'b1);
        do_window("jreg", 32'h0C00_0000, 3'd2, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b1);
        do_window("j10a", 32'h7000_0010, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0010, 1'b1);
        // Conditional branches
        do_window("beq_t", 32'h7800_FFFE, 3'd1, 1'b1, 1'b0, 16'h0, 16'h000F, 1'b1);
        do_window("j10b", 32'h7000_0010, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0010, 1'b1);
        do_window("beq_n", 32'h7800_FFFE, 3'd1, 1'b0, 1'b1, 16'h0, 16'h0011, 1'b1);
        do_window("blt_t", 32'h7C00_0005, 3'd1, 1'b0, 1'b1, 16'h0, 16'h0017, 1'b1);
        do_window("blt_n", 32'h7C00_0005, 3'd1, 1'b1, 1'b0, 16'h0, 16'h0018, 1'b1);
        do_window("sel5", 32'h7000_0ABC, 3'd5, 1'b0, 1'b0, 16'h0, 16'h0019, 1'b1);
        // Wrap: forward increment and backward branch
        do_window("jffff", 32'h7000_FFFF, 3'd0, 1'b0, 1'b0, 16'h0, 16'hFFFF, 1'b1);
        do_window("wrap", 32'h0C00_0000, 3'd3, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1);
        do_window("bwrap", 32'h7800_FFFE, 3'd1, 1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b1);

        // Wait states: three cycles without ack
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait.stall", 32'(stall), 32'd1);
            chk("wait.req", 32'(imem_req), 32'd1);
            chk("wait.instr", instr, 32'h7800_FFFE);
        end
        do_window("wdone", 32'h0C00_0002, 3'd3, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b1);

        // Halt
        do_window("jabc", 32'h7000_0ABC, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0ABC, 1'b1);
        do_window("halt", 32'h0C00_0000, 3'd4, 1'b0, 1'b0, 16'h0, 16'h0ABC, 1'b0);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.stall", 32'(stall), 32'd1);
        imem_ack = 1'b1;
        pc_sel   = 3'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt.req_hold", 32'(imem_req), 32'd0);
            chk("halt.pc_hold", 32'(pc), 32'h0ABC);
        end
        imem_ack = 1'b0;

        // Leave HALT through reset, then reset during FETCH
        rst_n = 1'b0;
        #1;
        chk("hrst.halted", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_window("j40", 32'h7000_0040, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0040, 1'b1);
        tick();
        chk("mid.req_before", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.req", 32'(imem_req), 32'd0);
        chk("mid.pc", 32'(pc), 32'h0);
        chk("mid.addr", 32'(imem_addr), 32'h0);
        chk("mid.instr", instr, 32'h0);
        chk("mid.stall", 32'(stall), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid.discard_stall", 32'(stall), 32'd1);
        chk("mid.discard_req", 32'(imem_req), 32'd1);
        chk("mid.discard_instr", instr, 32'h0);
        imem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: 16 FETCH cycles without ack
        repeat (15) tick();
        chk("wd.pre_ferr", 32'(fetch_err), 32'd0);
        chk("wd.pre_req", 32'(imem_req), 32'd1);
        tick();
        chk("wd.ferr", 32'(fetch_err), 32'd1);
        chk("wd.opcode", 32'(opcode), 32'd0);
        chk("wd.stall", 32'(stall), 32'd0);
        pc_sel = 3'd3;
        repeat (8) tick();
        chk("wd.halted", 32'(halted), 32'd1);
        chk("wd.ferr_sticky", 32'(fetch_err), 32'd1);
`else
        // No watchdog: FETCH waits indefinitely
        repeat (40) tick();
        chk("nowd.req", 32'(imem_req), 32'd1);
        chk("nowd.stall", 32'(stall), 32'd1);
        chk("nowd.halted", 32'(halted), 32'd0);
        chk("nowd.ferr", 32'(fetch_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
